// File: rtl/counter_step_ctrl.sv
// Pushbutton front end for the up/down counter: per-button sync and debounce,
// then a press FSM that emits single-cycle step pulses with hold-to-repeat.

module counter_step_db #(
   parameter int unsigned CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o
);

   localparam int unsigned CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(CYCLES);

   logic          s1_q;
   logic          s2_q;
   logic          lvl_q;
   logic          lvl_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CW'(1);

   // The count only survives while the synced level disagrees with the
   // accepted level; any agreement restarts the qualification window.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s2_q != lvl_q) begin
         if (cnt_inc == CMAX) begin
            lvl_d = s2_q;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         lvl_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = lvl_q;

endmodule

module counter_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 20,
   parameter int unsigned REPEAT_RATE     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic direction,
   output logic holding
);

   localparam int unsigned RMAX =
      (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RCW = $clog2(RMAX + 1);
   localparam logic [RCW-1:0] DELAY_LD = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] RATE_LD  = RCW'(REPEAT_RATE - 1);
   localparam logic [RCW-1:0] ONE      = RCW'(1);

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      REPEAT_WAIT,
      REPEAT_PULSE,
      REPEATING
   } state_t;

   state_t         state_q;
   logic [RCW-1:0] rcnt_q;
   logic           up_lvl;
   logic           dn_lvl;
   logic           sel;
   logic           sel_dir;
   logic           keep;

   counter_step_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_up),
      .level_o (up_lvl)
   );

   counter_step_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_down),
      .level_o (dn_lvl)
   );

   assign sel     = up_lvl ^ dn_lvl;
   assign sel_dir = up_lvl;
   // The held press stays valid only while the same single button is down.
   assign keep    = sel && (sel_dir == direction);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rcnt_q    <= '0;
         enable    <= 1'b0;
         direction <= 1'b1;
         holding   <= 1'b0;
      end else begin
         enable  <= 1'b0;
         holding <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (sel) begin
                  state_q   <= FIRST;
                  enable    <= 1'b1;
                  direction <= sel_dir;
               end
            end
            FIRST: begin
               state_q <= REPEAT_WAIT;
               rcnt_q  <= DELAY_LD;
               holding <= 1'b1;
            end
            REPEAT_WAIT, REPEATING: begin
               if (!keep) begin
                  state_q <= IDLE;
               end else if (rcnt_q <= ONE) begin
                  state_q <= REPEAT_PULSE;
                  rcnt_q  <= '0;
                  enable  <= 1'b1;
               end else begin
                  rcnt_q  <= rcnt_q - ONE;
                  holding <= 1'b1;
               end
            end
            REPEAT_PULSE: begin
               if (!keep) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= REPEATING;
                  rcnt_q  <= RATE_LD;
                  holding <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl: pulse timing, repeat spacing,
// glitch rejection, two-button lockout and async reset, with a counter model.

module tb_counter_step_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic enable;
   logic direction;
   logic holding;

   int tests = 0;
   int fails = 0;

   int       edge_n = 0;
   int       np = 0;
   int       pulse_e [64];
   logic     pulse_d [64];
   logic [7:0] model = 8'd0;
   logic     prev_en = 1'b0;
   logic     dbl = 1'b0;

   counter_step_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .enable    (enable),
      .direction (direction),
      .holding   (holding)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Record every step pulse and drive a downstream 8-bit counter model.
   always @(negedge clk) begin
      prev_en <= enable;
      if (enable && prev_en) dbl <= 1'b1;
      if (enable && !rst) begin
         if (np < 64) begin
            pulse_e[np] <= edge_n;
            pulse_d[np] <= direction;
         end
         np    <= np + 1;
         model <= direction ? model + 8'd1 : model - 8'd1;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      idle(3);
      tests++;
      if (enable !== 1'b0) begin
         fails++;
         $display("FAIL reset_enable got %b exp 0", enable);
      end
      tests++;
      if (direction !== 1'b1) begin
         fails++;
         $display("FAIL reset_direction got %b exp 1", direction);
      end
      tests++;
      if (holding !== 1'b0) begin
         fails++;
         $display("FAIL reset_holding got %b exp 0", holding);
      end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_glitch;
      int np0;
      np0 = np;
      @(negedge clk);
      btn_up = 1'b1;
      idle(3);
      btn_up = 1'b0;
      idle(15);
      tests++;
      if (np - np0 !== 0) begin
         fails++;
         $display("FAIL glitch_pulses got %0d exp 0", np - np0);
      end
      tests++;
      if (model !== 8'd0) begin
         fails++;
         $display("FAIL glitch_counter got %0d exp 0", model);
      end
   endtask

   task automatic test_single;
      int np0;
      int k;
      np0 = np;
      @(negedge clk);
      k = edge_n;
      btn_up = 1'b1;
      idle(10);
      btn_up = 1'b0;
      idle(15);
      tests++;
      if (np - np0 !== 1) begin
         fails++;
         $display("FAIL single_pulses got %0d exp 1", np - np0);
      end
      tests++;
      if (pulse_e[np0] !== k + 7) begin
         fails++;
         $display("FAIL single_latency got %0d exp %0d", pulse_e[np0], k + 7);
      end
      tests++;
      if (pulse_d[np0] !== 1'b1) begin
         fails++;
         $display("FAIL single_dir got %b exp 1", pulse_d[np0]);
      end
      tests++;
      if (model !== 8'd1) begin
         fails++;
         $display("FAIL single_counter got %0d exp 1", model);
      end
      tests++;
      if (direction !== 1'b1) begin
         fails++;
         $display("FAIL single_dir_hold got %b exp 1", direction);
      end
   endtask

   task automatic test_repeat;
      int np0;
      int k;
      int offs [4];
      offs = '{0, 20, 25, 30};
      np0 = np;
      @(negedge clk);
      k = edge_n;
      btn_down = 1'b1;
      idle(15);
      tests++;
      if (holding !== 1'b1) begin
         fails++;
         $display("FAIL repeat_holding got %b exp 1", holding);
      end
      idle(19);
      btn_down = 1'b0;
      idle(20);
      tests++;
      if (np - np0 !== 4) begin
         fails++;
         $display("FAIL repeat_pulses got %0d exp 4", np - np0);
      end
      tests++;
      if (pulse_e[np0] !== k + 7) begin
         fails++;
         $display("FAIL repeat_first got %0d exp %0d", pulse_e[np0], k + 7);
      end
      for (int i = 1; i < 4; i++) begin
         tests++;
         if (pulse_e[np0 + i] - pulse_e[np0] !== offs[i]) begin
            fails++;
            $display("FAIL repeat_offset%0d got %0d exp %0d", i,
                     pulse_e[np0 + i] - pulse_e[np0], offs[i]);
         end
         tests++;
         if (pulse_d[np0 + i] !== 1'b0) begin
            fails++;
            $display("FAIL repeat_dir%0d got %b exp 0", i, pulse_d[np0 + i]);
         end
      end
      tests++;
      if (model !== 8'd253) begin
         fails++;
         $display("FAIL repeat_counter got %0d exp 253", model);
      end
      tests++;
      if (holding !== 1'b0) begin
         fails++;
         $display("FAIL repeat_release_holding got %b exp 0", holding);
      end
   endtask

   task automatic test_both;
      int np0;
      int k;
      np0 = np;
      @(negedge clk);
      k = edge_n;
      btn_up = 1'b1;
      idle(12);
      btn_down = 1'b1;
      idle(28);
      tests++;
      if (np - np0 !== 1) begin
         fails++;
         $display("FAIL both_lockout got %0d exp 1", np - np0);
      end
      btn_up = 1'b0;
      idle(15);
      tests++;
      if (np - np0 !== 2) begin
         fails++;
         $display("FAIL both_fresh_pulses got %0d exp 2", np - np0);
      end
      tests++;
      if (pulse_e[np0 + 1] !== k + 47) begin
         fails++;
         $display("FAIL both_fresh_time got %0d exp %0d",
                  pulse_e[np0 + 1], k + 47);
      end
      tests++;
      if (pulse_d[np0 + 1] !== 1'b0) begin
         fails++;
         $display("FAIL both_fresh_dir got %b exp 0", pulse_d[np0 + 1]);
      end
      tests++;
      if (direction !== 1'b0) begin
         fails++;
         $display("FAIL both_direction got %b exp 0", direction);
      end
      btn_down = 1'b0;
      idle(20);
      tests++;
      if (model !== 8'd253) begin
         fails++;
         $display("FAIL both_counter got %0d exp 253", model);
      end
   endtask

   task automatic test_bounce;
      int np0;
      int k;
      np0 = np;
      @(negedge clk);
      k = edge_n;
      for (int i = 0; i < 8; i++) begin
         btn_up = (i % 2 == 0);
         @(negedge clk);
      end
      btn_up = 1'b1;
      idle(10);
      btn_up = 1'b0;
      idle(15);
      tests++;
      if (np - np0 !== 1) begin
         fails++;
         $display("FAIL bounce_pulses got %0d exp 1", np - np0);
      end
      tests++;
      if (pulse_e[np0] !== k + 15) begin
         fails++;
         $display("FAIL bounce_time got %0d exp %0d", pulse_e[np0], k + 15);
      end
      tests++;
      if (model !== 8'd254) begin
         fails++;
         $display("FAIL bounce_counter got %0d exp 254", model);
      end
   endtask

   task automatic test_reset_mid;
      int np0;
      int k;
      int j;
      np0 = np;
      @(negedge clk);
      k = edge_n;
      btn_down = 1'b1;
      idle(30);
      tests++;
      if (holding !== 1'b1 || direction !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_pre got hold=%b dir=%b exp hold=1 dir=0",
                  holding, direction);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (enable !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_enable got %b exp 0", enable);
      end
      tests++;
      if (holding !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_holding got %b exp 0", holding);
      end
      tests++;
      if (direction !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_direction got %b exp 1", direction);
      end
      idle(2);
      j = edge_n;
      rst = 1'b0;
      idle(10);
      tests++;
      if (np - np0 !== 3) begin
         fails++;
         $display("FAIL rstmid_pulses got %0d exp 3", np - np0);
      end
      tests++;
      if (pulse_e[np0 + 2] !== j + 7) begin
         fails++;
         $display("FAIL rstmid_restart got %0d exp %0d",
                  pulse_e[np0 + 2], j + 7);
      end
      tests++;
      if (pulse_d[np0 + 2] !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_dir got %b exp 0", pulse_d[np0 + 2]);
      end
      btn_down = 1'b0;
      idle(20);
   endtask

   task automatic test_no_double;
      tests++;
      if (dbl !== 1'b0) begin
         fails++;
         $display("FAIL double_enable got %b exp 0", dbl);
      end
   endtask

   initial begin
      test_reset;
      test_glitch;
      test_single;
      test_repeat;
      test_both;
      test_bounce;
      test_reset_mid;
      test_no_double;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
